// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_NINE = 4'h9;

    // Double-dabble correction: a digit of 5 or more would exceed 9 after the next shift.
    function automatic logic [3:0] dabble_digit(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 cell for one BCD digit; no carry to the neighbouring digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    always_comb begin
        d_out = dabble_digit(d_in);
    end

endmodule

// File: rtl/bin_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready on both sides.
// One bit per SHIFT cycle; overflow is sticky over the whole conversion.
module bin_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int SAT_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int AW = 4 * DIGITS;

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  bin_sh_q, bin_sh_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     bcd_q, bcd_d;
    logic              ovf_out_q, ovf_out_d;

    logic [AW-1:0]     acc_adj, acc_shift;
    logic              ovf_shift;
    logic              accept, last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (acc_q[4*g +: 4]),
            .d_out (acc_adj[4*g +: 4])
        );
    end

    always_comb begin
        acc_shift = {acc_adj[AW-2:0], bin_sh_q[BIN_W-1]};
        // Any bit leaving the top digit belongs to a digit we do not have.
        ovf_shift = ovf_q | acc_adj[AW-1];
        accept    = (state_q == IDLE) && in_valid;
        last      = (state_q == SHIFT) && (cnt_q == CW'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == SHIFT);
        out_valid = (state_q == DONE);
        bcd_out   = bcd_q;
        overflow  = ovf_out_q;
    end

    always_comb begin
        bin_sh_d  = bin_sh_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        if (accept) begin
            bin_sh_d = bin_in;
            acc_d    = '0;
            ovf_d    = 1'b0;
            cnt_d    = CW'(BIN_W);
        end else if (state_q == SHIFT) begin
            bin_sh_d = bin_sh_q << 1;
            acc_d    = acc_shift;
            ovf_d    = ovf_shift;
            cnt_d    = cnt_q - CW'(1);
        end
        // Result registers load only on the transition into DONE.
        if (last) begin
            ovf_out_d = ovf_shift;
            bcd_d     = (ovf_shift && (SAT_EN != 0)) ? {DIGITS{BCD_NINE}} : acc_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sh_q  <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            bin_sh_q  <= bin_sh_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
        end
    end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Directed bench for bin_bcd_seq: a 3-digit converter plus two 2-digit ones
// (saturating and truncating) driven in lockstep from the same stimulus.
module tb_bin_bcd_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] bin_in = '0;
    logic       out_ready = 1'b0;

    logic        in_ready, out_valid, busy, overflow;
    logic [11:0] bcd_out;
    logic        in_ready_s, out_valid_s, busy_s, ovf_s;
    logic [7:0]  bcd_s;
    logic        in_ready_n, out_valid_n, busy_n, ovf_n;
    logic [7:0]  bcd_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bin_bcd_seq #(.BIN_W(8), .DIGITS(3), .SAT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .overflow(overflow), .busy(busy)
    );

    bin_bcd_seq #(.BIN_W(8), .DIGITS(2), .SAT_EN(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .bin_in(bin_in), .out_valid(out_valid_s), .out_ready(out_ready),
        .bcd_out(bcd_s), .overflow(ovf_s), .busy(busy_s)
    );

    bin_bcd_seq #(.BIN_W(8), .DIGITS(2), .SAT_EN(0)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .bin_in(bin_in), .out_valid(out_valid_n), .out_ready(out_ready),
        .bcd_out(bcd_n), .overflow(ovf_n), .busy(busy_n)
    );

    function automatic logic [39:0] to_bcd(input int v);
        logic [39:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Starts and ends #1 after a rising edge; leaves the DUT in DONE when ok=1.
    task automatic do_conv(input int v, output bit ok);
        bit acc;
        int n;
        in_valid = 1'b1;
        bin_in   = 8'(v);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = acc && out_valid;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b, want 1 0 0", in_ready, busy, out_valid); end
        checks++; if (bcd_out !== 12'h000 || overflow !== 1'b0)
            begin errors++; $display("FAIL reset_data: bcd=%h ovf=%b, want 000 0", bcd_out, overflow); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        bit early = 1'b0;
        in_valid = 1'b1; bin_in = 8'd255; out_ready = 1'b1;
        @(posedge clk); #1;           // acceptance edge, edge 1
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL lat_busy: busy=%b in_ready=%b, want 1 0", busy, in_ready); end
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) early = 1'b1;
        end
        @(posedge clk); #1;           // edge BIN_W+1
        checks++; if (early !== 1'b0 || out_valid !== 1'b1)
            begin errors++; $display("FAIL lat_edge: early=%b out_valid=%b, want 0 1", early, out_valid); end
        checks++; if (bcd_out !== 12'h255 || overflow !== 1'b0)
            begin errors++; $display("FAIL lat_255: bcd=%h ovf=%b, want 255 0", bcd_out, overflow); end
        checks++; if (bcd_s !== 8'h99 || ovf_s !== 1'b1 || bcd_n !== 8'h55 || ovf_n !== 1'b1)
            begin errors++; $display("FAIL lat_255_2dig: sat=%h/%b trunc=%h/%b, want 99/1 55/1", bcd_s, ovf_s, bcd_n, ovf_n); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL lat_retire: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ir_bad = 1'b0;
        bit early = 1'b0;
        in_valid = 1'b1; bin_in = 8'd0; out_ready = 1'b1;
        @(posedge clk); #1;           // accept 0
        bin_in = 8'd99;               // must not disturb the conversion in flight
        for (int k = 0; k < 8; k++) begin
            if (in_ready) ir_bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (ir_bad !== 1'b0 || in_ready !== 1'b0)
            begin errors++; $display("FAIL b2b_ready1: in_ready went high during SHIFT/DONE (now %b)", in_ready); end
        checks++; if (out_valid !== 1'b1 || bcd_out !== 12'h000 || overflow !== 1'b0)
            begin errors++; $display("FAIL b2b_zero: valid=%b bcd=%h ovf=%b, want 1 000 0", out_valid, bcd_out, overflow); end
        @(posedge clk); #1;           // retire
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL b2b_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid); end
        @(posedge clk); #1;           // accept 99
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL b2b_accept2: in_ready=%b busy=%b, want 0 1", in_ready, busy); end
        for (int k = 0; k < 8; k++) begin
            if (out_valid) early = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (early !== 1'b0 || out_valid !== 1'b1 || bcd_out !== 12'h099 || overflow !== 1'b0)
            begin errors++; $display("FAIL b2b_99: early=%b valid=%b bcd=%h ovf=%b, want 0 1 099 0", early, out_valid, bcd_out, overflow); end
        checks++; if (bcd_s !== 8'h99 || ovf_s !== 1'b0 || bcd_n !== 8'h99 || ovf_n !== 1'b0)
            begin errors++; $display("FAIL b2b_99_2dig: sat=%h/%b trunc=%h/%b, want 99/0 99/0", bcd_s, ovf_s, bcd_n, ovf_n); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        bit ok;
        do_conv(200, ok);
        checks++; if (!ok || bcd_out !== 12'h200 || overflow !== 1'b0)
            begin errors++; $display("FAIL ovf_200_3dig: ok=%b bcd=%h ovf=%b, want 1 200 0", ok, bcd_out, overflow); end
        checks++; if (bcd_s !== 8'h99 || ovf_s !== 1'b1)
            begin errors++; $display("FAIL ovf_200_sat: bcd=%h ovf=%b, want 99 1", bcd_s, ovf_s); end
        checks++; if (bcd_n !== 8'h00 || ovf_n !== 1'b1)
            begin errors++; $display("FAIL ovf_200_trunc: bcd=%h ovf=%b, want 00 1", bcd_n, ovf_n); end
        retire();
        do_conv(100, ok);
        checks++; if (!ok || bcd_s !== 8'h99 || ovf_s !== 1'b1 || bcd_n !== 8'h00 || ovf_n !== 1'b1)
            begin errors++; $display("FAIL ovf_100: ok=%b sat=%h/%b trunc=%h/%b, want 1 99/1 00/1", ok, bcd_s, ovf_s, bcd_n, ovf_n); end
        checks++; if (bcd_out !== 12'h100 || overflow !== 1'b0)
            begin errors++; $display("FAIL ovf_100_3dig: bcd=%h ovf=%b, want 100 0", bcd_out, overflow); end
        retire();
    endtask

    task automatic test_backpressure();
        bit ok;
        out_ready = 1'b0;
        do_conv(137, ok);
        checks++; if (!ok)
            begin errors++; $display("FAIL bp_timeout: no result for 137"); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || bcd_out !== 12'h137 || overflow !== 1'b0)
                begin errors++; $display("FAIL bp_hold%0d: valid=%b bcd=%h ovf=%b, want 1 137 0", k, out_valid, bcd_out, overflow); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || bcd_out !== 12'h137)
            begin errors++; $display("FAIL bp_release: valid=%b in_ready=%b bcd=%h, want 0 1 137", out_valid, in_ready, bcd_out); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        in_valid = 1'b1; bin_in = 8'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL rstmid_ctrl: busy=%b in_ready=%b valid=%b, want 0 1 0", busy, in_ready, out_valid); end
        checks++; if (bcd_out !== 12'h000 || overflow !== 1'b0)
            begin errors++; $display("FAIL rstmid_data: bcd=%h ovf=%b, want 000 0", bcd_out, overflow); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (out_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0)
            begin errors++; $display("FAIL rstmid_noresult: out_valid/busy seen=%b after abort, want 0", seen); end
        do_conv(42, ok);
        checks++; if (!ok || bcd_out !== 12'h042 || overflow !== 1'b0)
            begin errors++; $display("FAIL rstmid_42: ok=%b bcd=%h ovf=%b, want 1 042 0", ok, bcd_out, overflow); end
        retire();
    endtask

    task automatic test_exhaustive();
        bit p_timeout = 1'b0;
        int idx = 0;
        bit extra = 1'b0;
        fork
            begin
                for (int v = 0; v < 256; v++) begin
                    bit acc;
                    int n;
                    in_valid = 1'b1;
                    bin_in = 8'(v);
                    acc = 1'b0;
                    n = 0;
                    while (!acc && n < 2000) begin
                        acc = in_ready;
                        @(posedge clk); #1;
                        n++;
                    end
                    if (!acc) p_timeout = 1'b1;
                end
                in_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (idx < 256 && cyc < 20000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        logic [39:0] r;
                        logic [7:0]  e2s;
                        r = to_bcd(idx);
                        e2s = (idx > 99) ? 8'h99 : r[7:0];
                        checks++;
                        if (bcd_out !== r[11:0] || overflow !== 1'b0 ||
                            bcd_s !== e2s || ovf_s !== (idx > 99) ||
                            bcd_n !== r[7:0] || ovf_n !== (idx > 99) ||
                            out_valid_s !== 1'b1 || out_valid_n !== 1'b1) begin
                            errors++;
                            $display("FAIL exh_%0d: bcd=%h/%b sat=%h/%b trunc=%h/%b, want %h/0 %h/%b %h/%b",
                                     idx, bcd_out, overflow, bcd_s, ovf_s, bcd_n, ovf_n,
                                     r[11:0], e2s, (idx > 99), r[7:0], (idx > 99));
                        end
                        idx++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        checks++; if (p_timeout !== 1'b0 || idx != 256)
            begin errors++; $display("FAIL exh_count: results=%0d timeout=%b, want 256 0", idx, p_timeout); end
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid || busy || busy_s || busy_n || !in_ready_s || !in_ready_n) extra = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++; if (extra !== 1'b0)
            begin errors++; $display("FAIL exh_extra: activity after last result=%b, want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
